// File: rtl/vid_axis_pkg.sv
// Shared types and defaults for the D5M pixel-bus to AXI4-Stream video bridge.
package vid_axis_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DROP   = 2'd2
    } state_t;

    // FIFO entry layout at the default pixel width; the bridge packs the same
    // {sof, eol, data} order at whatever DATA_W it is built with.
    typedef struct packed {
        logic                  sof;
        logic                  eol;
        logic [DATA_W_DEF-1:0] data;
    } vid_entry_t;

    // A held pixel closes its line when the line or the frame has ended.
    function automatic logic line_end(input logic fval, input logic lval);
        return (!fval) || (!lval);
    endfunction

endpackage

// File: rtl/vid_axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Head word is presented whenever
// the FIFO is non-empty and reads as zero while empty. A push while full is
// accepted only if a pop happens in the same cycle.
module vid_axis_sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full      = (count_q == DEPTH_L);
    assign empty     = (count_q == {(AW+1){1'b0}});
    assign level     = count_q;
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign rdata     = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/vid_axis_bridge.sv
// D5M frame/line-valid pixel bus to AXI4-Stream video (tuser=SOF, tlast=EOL).
// Optional build macro VID_AXIS_DROP_FRAME_EN: after the first overflow the
// rest of the frame is discarded (DROP state) instead of single pixels.
module vid_axis_bridge
    import vid_axis_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          enable,
    input  logic                          ifval,
    input  logic                          ilval,
    input  logic [DATA_W-1:0]             idata,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tvalid,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              frame_count,
    output logic [CNT_W-1:0]              ovf_count
);

`ifdef VID_AXIS_DROP_FRAME_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    localparam int ENTRY_W = DATA_W + 2;

    state_t             state_q, state_d;
    logic               enable_q, enable_d;
    logic               ifval_q, ifval_d;
    logic               hold_vld_q, hold_vld_d;
    logic               hold_sof_q, hold_sof_d;
    logic [DATA_W-1:0]  hold_data_q, hold_data_d;
    logic               sof_pend_q, sof_pend_d;
    logic [CNT_W-1:0]   frame_count_q, frame_count_d;
    logic [CNT_W-1:0]   ovf_count_q, ovf_count_d;

    logic               start_s, ovf_evt_s, fifo_push_s, fifo_pop_s;
    logic               fifo_full_s, fifo_empty_s, pix_s;
    logic [1:0]         drop_inc_s;
    logic [ENTRY_W-1:0] fifo_wdata_s, fifo_rdata_s;

    // Saturating add of up to two dropped pixels per cycle.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign pix_s        = ifval && ilval;
    assign fifo_pop_s   = m_axis_tready && !fifo_empty_s;
    assign fifo_wdata_s = {hold_sof_q, line_end(ifval, ilval), hold_data_q};

    vid_axis_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .push  (fifo_push_s),
        .wdata (fifo_wdata_s),
        .pop   (fifo_pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    assign m_axis_tvalid = !fifo_empty_s;
    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = fifo_rdata_s;
    assign frame_count   = frame_count_q;
    assign ovf_count     = ovf_count_q;

    // Frame FSM: frames only start on an ifval rise with capture enabled.
    always_comb begin
        state_d       = state_q;
        enable_d      = enable_q;
        frame_count_d = frame_count_q;
        start_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ifval) begin
                    enable_d = enable;
                end else if (!ifval_q && enable_q) begin
                    state_d       = ACTIVE;
                    start_s       = 1'b1;
                    frame_count_d = frame_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (!ifval) begin
                    state_d = IDLE;
                end else if (ovf_evt_s && DROP_EN) begin
                    state_d = DROP;
                end else begin
                    state_d = ACTIVE;
                end
            end
            DROP: begin
                if (!ifval) begin
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold stage, FIFO write and drop accounting.
    always_comb begin
        hold_vld_d  = 1'b0;
        hold_sof_d  = hold_sof_q;
        hold_data_d = hold_data_q;
        sof_pend_d  = sof_pend_q;
        fifo_push_s = 1'b0;
        ovf_evt_s   = 1'b0;
        drop_inc_s  = 2'd0;
        // Flush last cycle's pixel; its eol comes from this cycle's strobes.
        if (hold_vld_q) begin
            if (fifo_full_s && !fifo_pop_s) begin
                ovf_evt_s  = 1'b1;
                drop_inc_s = 2'd1;
            end else begin
                fifo_push_s = 1'b1;
            end
        end else begin
            fifo_push_s = 1'b0;
        end
        if (start_s) begin
            sof_pend_d = 1'b1;
        end else if ((state_q == ACTIVE) && pix_s && !(ovf_evt_s && DROP_EN)) begin
            hold_vld_d  = 1'b1;
            hold_sof_d  = sof_pend_q;
            hold_data_d = idata;
            sof_pend_d  = 1'b0;
        end else if (pix_s && (state_q != IDLE)) begin
            drop_inc_s = drop_inc_s + 2'd1;
        end else begin
            sof_pend_d = sof_pend_q;
        end
        ifval_d     = ifval;
        ovf_count_d = sat_add(ovf_count_q, drop_inc_s);
    end

    // State, hold and counter registers. ifval_q resets high so a frame
    // already in progress at reset release is not mistaken for a new one.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= IDLE;
            enable_q      <= 1'b0;
            ifval_q       <= 1'b1;
            hold_vld_q    <= 1'b0;
            hold_sof_q    <= 1'b0;
            hold_data_q   <= {DATA_W{1'b0}};
            sof_pend_q    <= 1'b0;
            frame_count_q <= {CNT_W{1'b0}};
            ovf_count_q   <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            enable_q      <= enable_d;
            ifval_q       <= ifval_d;
            hold_vld_q    <= hold_vld_d;
            hold_sof_q    <= hold_sof_d;
            hold_data_q   <= hold_data_d;
            sof_pend_q    <= sof_pend_d;
            frame_count_q <= frame_count_d;
            ovf_count_q   <= ovf_count_d;
        end
    end

endmodule
